// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the two-requester ALU arbiter: ops, FSM states, result constants.
// No logic here; types and constants only.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [31:0] DIV_ZERO_RESULT = 32'hFFFF_FFFF;
  localparam int          CNT_W           = 5;

  typedef struct packed {
    logic        id;
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
  } op_req_t;

  function automatic logic is_div_zero(input op_req_t r);
    return (r.op == OP_DIV) && (r.b == 32'd0);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, one consumer and the arbiter.
// slave = arbiter side, master = requesters plus result consumer.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req0_op;
  logic [1:0]  req1_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: add/sub/mul/div plus logic ops; zero latency, no handshake.
// signed_mode selects signed mul/div, high_word returns the upper half of the product.
module alu_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  opcode,
  input  logic        signed_mode,
  input  logic        high_word,
  output logic [31:0] y
);
  logic [63:0] prod;
  logic [31:0] quo;

  always_comb begin
    prod = 64'd0;
    quo  = 32'd0;
    if (signed_mode) begin
      prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    end else begin
      prod = {32'd0, a} * {32'd0, b};
    end
    // Zero divisor yields 0 here; callers that need a flag test b themselves.
    if (b != 32'd0) begin
      if (signed_mode) begin
        quo = $signed(a) / $signed(b);
      end else begin
        quo = a / b;
      end
    end
  end

  always_comb begin
    y = 32'd0;
    case (opcode)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = high_word ? prod[63:32] : prod[31:0];
      3'b011:  y = quo;
      3'b100:  y = a & b;
      3'b101:  y = a | b;
      3'b110:  y = a ^ b;
      default: y = a;
    endcase
  end
endmodule

// File: rtl/alu_rr_pick.sv
// 2-way round-robin grant: a lone requester wins, on contention the pointer decides.
// Purely combinational; no state, no backpressure of its own.
module alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  always_comb begin
    gnt_id = 1'b0;
    gnt    = 2'b00;
    case (valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr;
      default: gnt_id = 1'b0;
    endcase
    if (valid != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one ALU; result after op-dependent N edges (add/sub, mul, div).
// One op in flight; req_ready stays low in BUSY/DONE and the result holds until rsp_ready.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int ADDSUB_CYCLES = 1,
  parameter int MUL_CYCLES    = 4,
  parameter int DIV_CYCLES    = 16
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] ADDSUB_LOAD = CNT_W'(ADDSUB_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD    = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD    = CNT_W'(DIV_CYCLES - 1);

  state_e           state, state_nxt;
  logic             ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;
  op_req_t          cur;
  op_e              sel_op;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             accept;
  logic [31:0]      alu_y;
  logic [31:0]      rsp_data_q;
  logic             rsp_id_q;
  logic             rsp_err_q;

  alu_rr_pick u_pick (
    .valid  (bus.req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  alu_core u_alu (
    .a           (cur.a),
    .b           (cur.b),
    .opcode      ({1'b0, cur.op}),
    .signed_mode (1'b0),
    .high_word   (1'b0),
    .y           (alu_y)
  );

  assign accept = (state == ST_IDLE) && (gnt != 2'b00);

  always_comb begin
    sel_op   = op_e'(gnt_id ? bus.req1_op : bus.req0_op);
    cnt_load = ADDSUB_LOAD;
    case (sel_op)
      OP_MUL:  cnt_load = MUL_LOAD;
      OP_DIV:  cnt_load = DIV_LOAD;
      default: cnt_load = ADDSUB_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    case (state)
      ST_IDLE: begin
        bus.req_ready = gnt;
        if (accept) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= 1'b0;
      cnt        <= '0;
      cur        <= '0;
      rsp_data_q <= 32'd0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur <= '{id: gnt_id,
                     op: sel_op,
                     a:  gnt_id ? bus.req1_a : bus.req0_a,
                     b:  gnt_id ? bus.req1_b : bus.req0_b};
            cnt <= cnt_load;
            ptr <= ~gnt_id;
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_id_q <= cur.id;
            if (is_div_zero(cur)) begin
              rsp_data_q <= DIV_ZERO_RESULT;
              rsp_err_q  <= 1'b1;
            end else begin
              rsp_data_q <= alu_y;
              rsp_err_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (state == ST_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: drivers push expected responses, a monitor pops and compares.
// Covers grant order, latency per op, div-by-zero, result backpressure and reset mid-op.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int ADDSUB_N = 1;
  localparam int MUL_N    = 4;
  localparam int DIV_N    = 16;
  localparam int NV       = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_arbiter_if bus ();

  alu_arbiter #(
    .ADDSUB_CYCLES (ADDSUB_N),
    .MUL_CYCLES    (MUL_N),
    .DIV_CYCLES    (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        e;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NV];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   rsp_seen = 0;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: sample late in the low phase so driver changes made after the falling edge are seen.
  initial begin
    bit          was_valid;
    logic [31:0] h_data;
    logic        h_id;
    logic        h_err;
    int          rise;
    exp_t        e;
    was_valid = 1'b0;
    rise      = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        was_valid = 1'b0;
      end else begin
        if (bus.rsp_valid) begin
          if (!was_valid) begin
            rise   = cyc;
            h_data = bus.rsp_data;
            h_id   = bus.rsp_id;
            h_err  = bus.rsp_err;
          end else begin
            check("hold_data", bus.rsp_data, h_data);
            check("hold_id", 32'(bus.rsp_id), 32'(h_id));
            check("hold_err", 32'(bus.rsp_err), 32'(h_err));
          end
          if (bus.rsp_ready) begin
            rsp_seen++;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_rsp: got data %h id %0d, required no response",
                       bus.rsp_data, bus.rsp_id);
            end else begin
              e = sb.pop_front();
              check("rsp_data", bus.rsp_data, e.data);
              check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
              check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
              check("rsp_latency", 32'(rise - e.acc), 32'(e.lat));
            end
          end
        end
        was_valid = bus.rsp_valid && !bus.rsp_ready;
      end
    end
  end

  // Entered just after a falling edge; returns just after the falling edge that precedes a grant.
  task automatic wait_grant(output bit ok, output int waited);
    ok     = 1'b0;
    waited = 0;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        ok     = 1'b1;
        waited = t;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_req(input logic id, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] d, input logic e,
                        input int lat);
    bit ok;
    int waited;
    if (id) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req_valid = 2'b10;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req_valid = 2'b01;
    end
    wait_grant(ok, waited);
    if (!ok) begin
      fail_now("grant_timeout");
      bus.req_valid = 2'b00;
      return;
    end
    check("req_ready", 32'(bus.req_ready), id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    sb.push_back('{id: id, data: d, err: e, lat: lat, acc: cyc});
    @(negedge clk);
    bus.req_valid = 2'b00;
  endtask

  // Both requesters held valid: req0 mul 6*5, req1 sub 9-4; grants must alternate.
  task automatic do_pair(input int n, input logic first, output int first_wait);
    bit   ok;
    int   waited;
    logic exp_id;
    first_wait  = -1;
    bus.req0_op = OP_MUL; bus.req0_a = 32'd6; bus.req0_b = 32'd5;
    bus.req1_op = OP_SUB; bus.req1_a = 32'd9; bus.req1_b = 32'd4;
    bus.req_valid = 2'b11;
    for (int k = 0; k < n; k++) begin
      exp_id = first ^ 1'(k % 2);
      wait_grant(ok, waited);
      if (!ok) begin
        fail_now("pair_grant_timeout");
        break;
      end
      if (k == 0) first_wait = waited;
      check("grant_order", 32'(bus.req_ready), exp_id ? 32'd2 : 32'd1);
      @(posedge clk);
      #1;
      if (exp_id) sb.push_back('{id: 1'b1, data: 32'd5, err: 1'b0, lat: ADDSUB_N, acc: cyc});
      else        sb.push_back('{id: 1'b0, data: 32'd30, err: 1'b0, lat: MUL_N, acc: cyc});
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (sb.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) fail_now("drain_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    bit ok;
    int w;
    int seen0;

    vecs = '{
      '{1'b0, OP_ADD, 32'd6,         32'd5,       32'd11,        1'b0, ADDSUB_N},
      '{1'b1, OP_DIV, 32'd7,         32'd0,       32'hFFFF_FFFF, 1'b1, DIV_N},
      '{1'b0, OP_DIV, 32'd100,       32'd7,       32'd14,        1'b0, DIV_N},
      '{1'b1, OP_SUB, 32'd3,         32'd5,       32'hFFFF_FFFE, 1'b0, ADDSUB_N},
      '{1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd2,       32'd1,         1'b0, ADDSUB_N},
      '{1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,       1'b0, MUL_N},
      '{1'b0, OP_MUL, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFE, 1'b0, MUL_N},
      '{1'b1, OP_DIV, 32'h8000_0000, 32'd2,       32'h4000_0000, 1'b0, DIV_N},
      '{1'b0, OP_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,       1'b0, DIV_N}
    };

    bus.req_valid = 2'b00;
    bus.req0_op = 2'b00; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_op = 2'b00; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    @(negedge clk);
    reset = 1'b0;
    do_pair(4, 1'b0, w);
    check("first_edge_accept_wait", 32'(w), 32'd0);

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].e, vecs[i].lat);
    end

    // Result backpressure: hold rsp_ready low for 5 cycles in DONE.
    wait_drain();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    do_req(1'b1, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, ADDSUB_N);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("done_timeout");
    bus.req0_op = OP_ADD; bus.req1_op = OP_ADD;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      check("done_req_ready", 32'(bus.req_ready), 32'd0);
      check("done_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      @(negedge clk);
      #1;
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_rsp_busy", 32'(bus.busy), 32'd0);
    check("idle_after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);

    // Reset in the middle of a div, with the down-counter at 8; leaves the pointer at 1.
    do_req(1'b0, OP_DIV, 32'd50, 32'd5, 32'd10, 1'b0, DIV_N);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen0 = rsp_seen;
    repeat (30) @(negedge clk);
    #1;
    check("after_reset_busy", 32'(bus.busy), 32'd0);
    check("after_reset_no_rsp", 32'(rsp_seen), 32'(seen0));
    @(negedge clk);

    do_pair(2, 1'b0, w);
    do_req(1'b0, OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, ADDSUB_N);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ADDSUB_CYCLES, default 1, BUSY cycles for add/sub.
REQ-002 Parameter MUL_CYCLES, default 4, BUSY cycles for mul.
REQ-003 Parameter DIV_CYCLES, default 16, BUSY cycles for div; all cycle parameters SHALL be 1..31.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-007 req_ready  output  2  per-requester accept, at most one bit high.
REQ-008 req0_op, req1_op  input  2 each  00 add, 01 sub, 10 mul, 11 div.
REQ-009 req0_a, req0_b, req1_a, req1_b  input  32 each  operands A and B.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  1  requester that owns the result.
REQ-013 rsp_data  output  32  ALU answer.
REQ-014 rsp_err  output  1  divide-by-zero flag.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, BUSY, DONE; transfers SHALL occur only on a rising edge with valid and ready both high.
REQ-017 IDLE: req_ready SHALL be high for the granted requester only, combinationally from req_valid and the priority pointer; BUSY/DONE: req_ready SHALL be 00.
REQ-018 Grant: only one requester valid -> that one; both valid -> the requester named by the priority pointer.
REQ-019 On accept, the pointer SHALL become the non-granted requester id; the pointer is unchanged when nothing is accepted.
REQ-020 On accept, id, op, A, B SHALL be registered; the counter SHALL load (op cycles - 1); state -> BUSY.
REQ-021 Operand registers SHALL drive the ALU, with the op mapped to the 3-bit ALU opcode {1'b0, op}, stable throughout BUSY.
REQ-022 BUSY: counter != 0 -> decrement; counter == 0 -> register ALU answer into rsp_data, state -> DONE.
REQ-023 rsp_valid SHALL rise exactly N edges after the accepting edge, where N is the op's cycle parameter.
REQ-024 Div with B == 0: rsp_data SHALL be 32'hFFFF_FFFF and rsp_err 1, with unchanged latency; otherwise rsp_err SHALL be 0.
REQ-025 DONE: rsp_valid high; rsp_data/rsp_id/rsp_err SHALL hold stable until rsp_ready; on the transfer edge state -> IDLE.
REQ-026 No request SHALL be accepted on the DONE->IDLE edge; the earliest next accept is the following edge.
REQ-027 A requester dropping req_valid before acceptance SHALL cancel nothing in flight; requests are not queued.
REQ-028 Arithmetic SHALL be 32-bit modulo (low word), as produced by the ALU; no overflow flag.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, pointer = 0, counter = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0, busy = 0, and operand registers = 0.
REQ-030 Reset during BUSY or DONE SHALL discard the in-flight operation with no response.
REQ-031 The first edge after reset release SHALL be able to accept a request.

Structure
REQ-032 A shared package SHALL hold the 2-bit op encodings, the state encoding and the div-by-zero result constant.
REQ-033 A sub-module alu_rr_pick (2-way round-robin grant from valid bits and pointer) SHALL be used; the existing ALU SHALL be instantiated once, with its two mode inputs tied to 0.

Verification
REQ-034 Req0 add 6+5 alone, rsp_ready = 1 -> ready0 high in that cycle; rsp_valid 1 edge later; data 11, id 0, err 0.
REQ-035 Both valid, req0 mul 6*5, req1 sub 9-4 -> req0 is served first (data 30 after 4 edges), then req1 (data 5, id 1); with both held valid, grants alternate 0,1,0,1.
REQ-036 Req1 div 7/0 -> after 16 edges, data FFFF_FFFF, err 1.
REQ-037 rsp_ready held low for 5 cycles in DONE -> outputs stable; req_ready 00 throughout; IDLE one edge after rsp_ready rises.
REQ-038 Reset asserted mid-div, at counter 8 -> outputs are at reset values immediately; no response after release; a new add completes normally.
